// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the parametrised bus arbiter.
//   - Default parameter constants (masters, master-ID width, slaves, timeout width).
//   - Arbiter FSM state type; the encodings are visible on the debug 'state' output.
package bus_pkg;

  localparam int unsigned DEF_NUM_MASTERS = 12;
  localparam int unsigned DEF_MID_WIDTH   = 4;
  localparam int unsigned DEF_NUM_SLAVES  = 6;
  localparam int unsigned DEF_TIMEOUT_LEN = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    BUSY    = 3'd2,
    RELEASE = 3'd3
  } bus_state_e;

endpackage

// File: rtl/bus_arbiter_param_if.sv
// bus_arbiter_param_if: request/grant bundle between the bus masters and the arbiter.
//   Requester side -> arbiter: m_reqs, slave_busy, bus_util, arb_mode
//   Arbiter -> requester side: m_grants, mid_current, grant_valid, timeout_evt,
//                              state (debug), busy_cycles (debug)
//   modport master : environment / bus-master side (drives requests)
//   modport slave  : arbiter side (drives grants and debug outputs)
interface bus_arbiter_param_if
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned MID_WIDTH   = DEF_MID_WIDTH,
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES
);

  logic [NUM_MASTERS-1:0] m_reqs;
  logic [NUM_SLAVES-1:0]  slave_busy;
  logic                   bus_util;
  logic                   arb_mode;
  logic [NUM_MASTERS-1:0] m_grants;
  logic [MID_WIDTH-1:0]   mid_current;
  logic                   grant_valid;
  logic                   timeout_evt;
  logic [2:0]             state;
  logic [15:0]            busy_cycles;

  modport master (
    output m_reqs, slave_busy, bus_util, arb_mode,
    input  m_grants, mid_current, grant_valid, timeout_evt, state, busy_cycles
  );

  modport slave (
    input  m_reqs, slave_busy, bus_util, arb_mode,
    output m_grants, mid_current, grant_valid, timeout_evt, state, busy_cycles
  );

endinterface

// File: rtl/bus_arbiter_param_picker.sv
// rr_priority_picker: combinational winner selection for the bus arbiter.
//   req_i    : request vector
//   start_i  : round-robin start index (ignored in fixed-priority mode)
//   mode_i   : 0 = fixed priority (lowest index), 1 = round robin from start_i
//   grant_o  : one-hot winner (all zero when no request)
//   idx_o    : encoded winner index
//   any_o    : at least one request present
// The request vector is rotated down by the start index, the first set bit is
// found, and the resulting offset is rotated back to an absolute index.
module rr_priority_picker #(
  parameter int unsigned NUM_MASTERS = 12,
  parameter int unsigned IDX_W       = 4
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       start_i,
  input  logic                   mode_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  int unsigned              base;
  int unsigned              first;
  int unsigned              pos;
  logic                     found;

  always_comb begin
    base  = mode_i ? int'(start_i) : 0;
    dbl   = {req_i, req_i};
    rot   = NUM_MASTERS'(dbl >> base);
    found = 1'b0;
    first = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = i;
      end
    end
    pos = first + base;
    if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
    idx_o = IDX_W'(pos);
    any_o = found;
    grant_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      grant_o[i] = found && (i == pos);
    end
  end

endmodule

// File: rtl/bus_arbiter_param.sv
// bus_arbiter_param: parametrised arbiter for the shared one-wire data bus.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : bus_arbiter_param_if.slave bundle
//     in : m_reqs (level requests), slave_busy (blocks new grants),
//          bus_util (granted master transferring), arb_mode (0 fixed, 1 round robin)
//     out: m_grants (registered one-hot or zero), mid_current (granted/last-granted
//          index), grant_valid, timeout_evt (1-cycle pulse), state (debug FSM code),
//          busy_cycles (BUSY-cycle count)
// Optional build macro: BUS_PERF_CNT_EN enables the saturating busy_cycles
// counter; when undefined busy_cycles is tied to zero.
module bus_arbiter_param
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned MID_WIDTH   = DEF_MID_WIDTH,
  parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int unsigned TIMEOUT_LEN = DEF_TIMEOUT_LEN
) (
  input logic               clk,
  input logic               rst,
  bus_arbiter_param_if.slave bus
);

  localparam logic [TIMEOUT_LEN-1:0] TMO_LAST = '1;

  bus_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MID_WIDTH-1:0]   mid_q, mid_d;
  logic [MID_WIDTH-1:0]   rr_q, rr_d;
  logic                   gv_q, gv_d;
  logic                   tmo_q, tmo_d;
  logic [TIMEOUT_LEN-1:0] cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [MID_WIDTH-1:0]   pick_idx;
  logic                   pick_any;
  logic                   start_grant;
  logic                   req_held;
  logic                   tmo_hit;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (MID_WIDTH)
  ) u_picker (
    .req_i   (bus.m_reqs),
    .start_i (rr_q),
    .mode_i  (bus.arb_mode),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign start_grant = (state_q == IDLE) && pick_any && !(|bus.slave_busy);
  assign req_held    = bus.m_reqs[mid_q];
  // Counter value after this cycle's increment reaching the terminal count.
  assign tmo_hit     = (cnt_q + TIMEOUT_LEN'(1)) == TMO_LAST;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      mid_q   <= '0;
      rr_q    <= '0;
      gv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mid_q   <= mid_d;
      rr_q    <= rr_d;
      gv_q    <= gv_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_grant) state_d = GRANT;
      GRANT: begin
        if (bus.bus_util)  state_d = BUSY;
        else if (!req_held) state_d = RELEASE;
        else if (tmo_hit)   state_d = RELEASE;
      end
      BUSY:    if (!bus.bus_util) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; grant is dropped on the same edge that
  // enters RELEASE so that RELEASE shows an all-zero grant.
  always_comb begin
    grant_d = grant_q;
    mid_d   = mid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        grant_d = '0;
        if (start_grant) begin
          grant_d = pick_oh;
          mid_d   = pick_idx;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + TIMEOUT_LEN'(1);
        if (state_d == BUSY)    cnt_d = '0;
        if (state_d == RELEASE) grant_d = '0;
        tmo_d = !bus.bus_util && req_held && tmo_hit;
      end
      BUSY: begin
        if (state_d == RELEASE) grant_d = '0;
      end
      RELEASE: begin
        grant_d = '0;
        rr_d    = (mid_q == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : mid_q + MID_WIDTH'(1);
      end
      default: grant_d = '0;
    endcase
    gv_d = |grant_d;
  end

`ifdef BUS_PERF_CNT_EN
  logic [15:0] busy_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else if (state_q == BUSY && busy_cnt_q != '1) begin
      busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  assign bus.busy_cycles = busy_cnt_q;
`else
  assign bus.busy_cycles = '0;
`endif

  assign bus.m_grants    = grant_q;
  assign bus.mid_current = mid_q;
  assign bus.grant_valid = gv_q;
  assign bus.timeout_evt = tmo_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb_bus_arbiter_param: directed scenarios plus randomized traffic for
// bus_arbiter_param, checked every cycle against a transaction-level model
// (phase + owner + round-robin pointer) kept in this file.
module tb_bus_arbiter_param;

  localparam int NM = 12;
  localparam int NS = 6;
  localparam int TL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_param_if #(.NUM_MASTERS(NM), .MID_WIDTH(4), .NUM_SLAVES(NS)) bif ();

  bus_arbiter_param #(
    .NUM_MASTERS (NM),
    .MID_WIDTH   (4),
    .NUM_SLAVES  (NS),
    .TIMEOUT_LEN (TL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 granted/awaiting use, 2 transferring, 3 released
  int m_phase, m_owner, m_ptr, m_wait, m_busy;
  bit m_tmo;

  function automatic int pick(input logic [NM-1:0] req, input int start);
    for (int k = 0; k < NM; k++) begin
      int j;
      j = (start + k) % NM;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic [NM-1:0] req, input logic [NS-1:0] sb,
                            input logic bu, input logic am);
    int prev;
    if (r) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0; m_busy = 0; m_tmo = 0;
    end else begin
      prev  = m_phase;
      m_tmo = 0;
      case (m_phase)
        0: if (req != 0 && sb == 0) begin
             m_owner = pick(req, am ? m_ptr : 0);
             m_phase = 1;
             m_wait  = 0;
           end
        1: begin
             m_wait++;
             if (bu) m_phase = 2;
             else if (!req[m_owner]) m_phase = 3;
             else if (m_wait == (1 << TL) - 1) begin m_tmo = 1; m_phase = 3; end
           end
        2: if (!bu) m_phase = 3;
        default: begin m_ptr = (m_owner + 1) % NM; m_phase = 0; end
      endcase
`ifdef BUS_PERF_CNT_EN
      if (prev == 2 && m_busy < 65535) m_busy++;
`endif
    end
  endtask

  task automatic compare_all();
    logic [NM-1:0] one, exp_g;
    one   = 12'd1;
    exp_g = (m_phase == 1 || m_phase == 2) ? (one << m_owner) : '0;
    check_val("grants",  32'(bif.m_grants),    32'(exp_g));
    check_val("mid",     32'(bif.mid_current), 32'(m_owner));
    check_val("gvalid",  32'(bif.grant_valid), 32'(exp_g != 0));
    check_val("timeout", 32'(bif.timeout_evt), 32'(m_tmo));
    check_val("state",   32'(bif.state),       32'(m_phase));
    check_val("busycyc", 32'(bif.busy_cycles), 32'(m_busy));
    check_val("onehot0", 32'($onehot0(bif.m_grants)), 32'd1);
  endtask

  task automatic tick(input logic r, input logic [NM-1:0] req, input logic [NS-1:0] sb,
                      input logic bu, input logic am);
    rst            = r;
    bif.m_reqs     = req;
    bif.slave_busy = sb;
    bif.bus_util   = bu;
    bif.arb_mode   = am;
    @(posedge clk);
    model_step(r, req, sb, bu, am);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic am);
    tick(1'b1, '0, '0, 1'b0, am);
    tick(1'b1, '0, '0, 1'b0, am);
    tick(1'b1, '0, '0, 1'b0, am);
  endtask

  int exp_rr[4] = '{2, 4, 5, 2};

  initial begin
    int n, gc, exp_busy;
    logic [NM-1:0] rq;
    logic [NS-1:0] sb;
    logic bu, am;

    // Reset and fixed priority
    do_reset(1'b0);
    check_val("rst_grants", 32'(bif.m_grants), 32'd0);
    tick(1'b0, 12'h024, '0, 1'b0, 1'b0);
    check_val("fp_grant", 32'(bif.m_grants), 32'h004);
    check_val("fp_mid",   32'(bif.mid_current), 32'd2);
    check_val("fp_state", 32'(bif.state), 32'd1);

    // Handshake: 10 cycles of bus_util, then release
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 12'h024, '0, 1'b1, 1'b0);
      check_val("hs_busy", 32'(bif.state), 32'd2);
    end
    tick(1'b0, 12'h024, '0, 1'b0, 1'b0);
    check_val("hs_rel_state", 32'(bif.state), 32'd3);
    check_val("hs_rel_grant", 32'(bif.m_grants), 32'd0);
    tick(1'b0, 12'h024, '0, 1'b0, 1'b0);
    check_val("hs_idle", 32'(bif.state), 32'd0);
    tick(1'b0, 12'h024, '0, 1'b0, 1'b0);
    check_val("hs_regrant", 32'(bif.m_grants), 32'h004);

    // Round robin with constant requests
    do_reset(1'b1);
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!bif.grant_valid && n < 10) begin
        tick(1'b0, 12'h034, '0, 1'b0, 1'b1);
        n++;
      end
      check_val("rr_wait", 32'(bif.grant_valid), 32'd1);
      check_val("rr_order", 32'(bif.mid_current), 32'(exp_rr[t]));
      for (int i = 0; i < 5; i++) tick(1'b0, 12'h034, '0, 1'b1, 1'b1);
      tick(1'b0, 12'h034, '0, 1'b0, 1'b1);
    end

    // Grant timeout
    do_reset(1'b0);
    tick(1'b0, 12'h010, '0, 1'b0, 1'b0);
    gc = (bif.state == 3'd1) ? 1 : 0;
    n  = 0;
    while (bif.state == 3'd1 && n < 100) begin
      tick(1'b0, 12'h010, '0, 1'b0, 1'b0);
      if (bif.state == 3'd1) gc++;
      n++;
    end
    check_val("tmo_grant_cycles", 32'(gc), 32'd63);
    check_val("tmo_pulse", 32'(bif.timeout_evt), 32'd1);
    check_val("tmo_drop", 32'(bif.m_grants), 32'd0);
    tick(1'b0, 12'h010, '0, 1'b0, 1'b0);
    check_val("tmo_pulse_end", 32'(bif.timeout_evt), 32'd0);
    tick(1'b0, 12'h010, '0, 1'b0, 1'b0);
    check_val("tmo_regrant", 32'(bif.m_grants), 32'h010);

    // Slave busy blocks grants
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 12'h004, 6'b001000, 1'b0, 1'b0);
      check_val("sb_block", 32'(bif.m_grants), 32'd0);
    end
    tick(1'b0, 12'h004, '0, 1'b0, 1'b0);
    check_val("sb_release", 32'(bif.m_grants), 32'h004);

    // Busy-cycle count and reset mid-transfer
    do_reset(1'b0);
    tick(1'b0, 12'h004, '0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) tick(1'b0, 12'h004, '0, 1'b1, 1'b0);
`ifdef BUS_PERF_CNT_EN
    exp_busy = 20;
`else
    exp_busy = 0;
`endif
    check_val("perf_count", 32'(bif.busy_cycles), 32'(exp_busy));
    tick(1'b1, 12'h004, '0, 1'b1, 1'b0);
    check_val("rst_mid_grant", 32'(bif.m_grants), 32'd0);
    check_val("rst_mid_busy",  32'(bif.busy_cycles), 32'd0);

    // Randomized traffic
    rq = 12'h0a5; sb = '0; bu = 1'b0; am = 1'b0;
    tick(1'b0, rq, sb, bu, am);
    for (int c = 0; c < 3000; c++) begin
      logic r;
      if ($urandom_range(7) == 0) rq[$urandom_range(NM - 1)] ^= 1'b1;
      sb = ($urandom_range(9) == 0) ? NS'($urandom) : '0;
      if ((c % 500) >= 400) bu = 1'b0;
      else if ($urandom_range(3) == 0) bu = ~bu;
      if (c % 200 == 0) am = ~am;
      r = ($urandom_range(499) == 0);
      tick(r, rq, sb, bu, am);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
